// File: rtl/axis_arb_pkg.sv
// Shared types and width helpers for the AXI-Stream packet arbiter.
package axis_arb_pkg;

  // Ceiling log2, never less than 1, so that index fields are always at least one bit wide.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  typedef enum logic {S_IDLE, S_XFER} state_t;

  localparam int DEF_NUM_PORTS     = 4;
  localparam int DEF_MAX_PKT_WORDS = 256;
  localparam int DEF_IDX_W         = clogb2(DEF_NUM_PORTS);
  localparam int DEF_CNT_W         = clogb2(DEF_MAX_PKT_WORDS);

endpackage

// File: rtl/axis_pkt_arbiter_rr_grant.sv
// Combinational round-robin picker: rotate requests to start after last_grant,
// take the lowest set bit, then rotate the result back into port numbering.
module rr_grant
  import axis_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [clogb2(N)-1:0]  last_grant,
  output logic [N-1:0]          gnt,
  output logic [clogb2(N)-1:0]  gnt_idx
);

  localparam int IW = clogb2(N);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [IW:0]    start;
  logic [IW:0]    sum;
  logic [IW-1:0]  off;

  always_comb begin
    start   = (last_grant == IW'(N-1)) ? '0 : ({1'b0, last_grant} + 1'b1);
    req_dbl = {req, req} >> start;
    req_rot = req_dbl[N-1:0];
    off     = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (req_rot[i]) off = IW'(i);
    end
    sum = start + {1'b0, off};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    gnt_idx = sum[IW-1:0];
    gnt     = (|req) ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// N-input round-robin AXI-Stream packet arbiter with a registered output stage.
// A grant is held for a whole packet; overlong packets are cut at MAX_PKT_WORDS beats.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS         = DEF_NUM_PORTS,
  parameter int C_AXIS_DATA_WIDTH = 32,
  parameter int MAX_PKT_WORDS     = DEF_MAX_PKT_WORDS
) (
  input  logic                                   s_axis_aclk,
  input  logic                                   s_axis_aresetn,
  input  logic [NUM_PORTS-1:0]                   s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                   s_axis_tready,
  input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [NUM_PORTS-1:0]                   s_axis_tlast,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]         m_axis_tstrb,
  output logic                                   m_axis_tlast,
  output logic [clogb2(NUM_PORTS)-1:0]           m_axis_tid,
  output logic [NUM_PORTS-1:0]                   grant,
  output logic                                   trunc_pulse
);

  localparam int IDX_W  = clogb2(NUM_PORTS);
  localparam int CNT_W  = clogb2(MAX_PKT_WORDS);
  localparam int W      = C_AXIS_DATA_WIDTH;
  localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;

  state_t              state, state_next;
  logic [NUM_PORTS-1:0] rr_gnt;
  logic [IDX_W-1:0]    rr_idx, grant_idx, last_grant;
  logic [CNT_W-1:0]    beat_cnt;
  logic                sel_valid, sel_last, out_free, accept, at_limit, beat_last;
  logic [W-1:0]        sel_data;
  logic [STRB_W-1:0]   sel_strb;

  rr_grant #(.N(NUM_PORTS)) u_rr_grant (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .gnt        (rr_gnt),
    .gnt_idx    (rr_idx)
  );

  always_comb begin
    sel_valid = s_axis_tvalid[grant_idx];
    sel_last  = s_axis_tlast[grant_idx];
    sel_data  = s_axis_tdata[grant_idx*W +: W];
    sel_strb  = s_axis_tstrb[grant_idx*STRB_W +: STRB_W];
    out_free  = !m_axis_tvalid || m_axis_tready;
    at_limit  = (beat_cnt == CNT_W'(MAX_PKT_WORDS-1));
    beat_last = sel_last || at_limit;
  end

  // Next state and per-port ready; only the granted port sees ready, and only in XFER.
  always_comb begin
    state_next    = state;
    s_axis_tready = '0;
    accept        = 1'b0;
    case (state)
      S_IDLE: begin
        if (|s_axis_tvalid) state_next = S_XFER;
      end
      S_XFER: begin
        s_axis_tready[grant_idx] = out_free;
        accept = sel_valid && out_free;
        if (accept && beat_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) state <= S_IDLE;
    else                 state <= state_next;
  end

  // Grant bookkeeping: the pointer only moves when a packet (or truncated piece) finishes.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      grant      <= '0;
      grant_idx  <= '0;
      last_grant <= IDX_W'(NUM_PORTS-1);
      beat_cnt   <= '0;
    end else if (state == S_IDLE && |s_axis_tvalid) begin
      grant     <= rr_gnt;
      grant_idx <= rr_idx;
    end else if (accept) begin
      if (beat_last) begin
        last_grant <= grant_idx;
        grant      <= '0;
        beat_cnt   <= '0;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      trunc_pulse   <= 1'b0;
    end else begin
      trunc_pulse <= 1'b0;
      if (accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= sel_data;
        m_axis_tstrb  <= sel_strb;
        m_axis_tlast  <= beat_last;
        m_axis_tid    <= grant_idx;
        trunc_pulse   <= at_limit && !sel_last;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
